// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shared constants and encodings for the shift arbiter
package shift_pkg;

    localparam int SHIFT_W = 32;
    localparam int AMT_W   = 5;

    localparam logic OP_SLL = 1'b0;
    localparam logic OP_SRA = 1'b1;

    localparam logic ID_ALU   = 1'b0;
    localparam logic ID_SERVO = 1'b1;

    typedef enum logic {
        RES_EMPTY = 1'b0,
        RES_FULL  = 1'b1
    } res_state_t;

endpackage

// File: rtl/shift_core.sv
// rtl/shift_core.sv - combinational 16/8/4/2/1 logarithmic shifter; SRA under SHIFT_ARBITER_SRA_EN
import shift_pkg::*;

module shift_core (
    input  logic [SHIFT_W-1:0] data,
    input  logic [AMT_W-1:0]   amt,
    input  logic               op,
    output logic [SHIFT_W-1:0] result
);

    logic [SHIFT_W-1:0] s16;
    logic [SHIFT_W-1:0] s8;
    logic [SHIFT_W-1:0] s4;
    logic [SHIFT_W-1:0] s2;

`ifdef SHIFT_ARBITER_SRA_EN
    logic right;
    logic fill;

    // Five binary-weighted stages; right shifts fill with the original sign bit
    always_comb begin
        right  = (op == OP_SRA);
        fill   = data[SHIFT_W-1];
        s16    = amt[4] ? (right ? {{16{fill}}, data[31:16]} : {data[15:0], 16'h0000}) : data;
        s8     = amt[3] ? (right ? {{8{fill}}, s16[31:8]}    : {s16[23:0], 8'h00})     : s16;
        s4     = amt[2] ? (right ? {{4{fill}}, s8[31:4]}     : {s8[27:0], 4'h0})       : s8;
        s2     = amt[1] ? (right ? {{2{fill}}, s4[31:2]}     : {s4[29:0], 2'b00})      : s4;
        result = amt[0] ? (right ? {fill, s2[31:1]}          : {s2[30:0], 1'b0})       : s2;
    end
`else
    logic unused_op;
    assign unused_op = op;

    // Left-shift only build: five zero-filling stages
    always_comb begin
        s16    = amt[4] ? {data[15:0], 16'h0000} : data;
        s8     = amt[3] ? {s16[23:0], 8'h00}     : s16;
        s4     = amt[2] ? {s8[27:0], 4'h0}       : s8;
        s2     = amt[1] ? {s4[29:0], 2'b00}      : s4;
        result = amt[0] ? {s2[30:0], 1'b0}       : s2;
    end
`endif

endmodule

// File: rtl/shift_arbiter.sv
// rtl/shift_arbiter.sv - two-requester arbiter around one shifter with registered output; SRA via SHIFT_ARBITER_SRA_EN
import shift_pkg::*;

module shift_arbiter #(
    parameter int PRIO_FIXED = 0
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic [SHIFT_W-1:0] req0_data,
    input  logic [AMT_W-1:0]   req0_amt,
    input  logic               req0_op,
    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic [SHIFT_W-1:0] req1_data,
    input  logic [AMT_W-1:0]   req1_amt,
    input  logic               req1_op,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [SHIFT_W-1:0] res_data,
    output logic               res_id
);

    res_state_t         state;
    logic               last;
    logic               tie_to_1;
    logic               gnt0;
    logic               gnt1;
    logic               can_accept;
    logic               accept;
    logic [SHIFT_W-1:0] sel_data;
    logic [AMT_W-1:0]   sel_amt;
    logic               sel_op;
    logic [SHIFT_W-1:0] shifted;

    // Grant selection, handshake and operand mux; ready is held low while in reset
    always_comb begin
        tie_to_1   = (PRIO_FIXED == 0) && (last == ID_ALU);
        gnt1       = req1_valid && (!req0_valid || tie_to_1);
        gnt0       = req0_valid && !gnt1;
        can_accept = !res_valid || res_ready;
        req0_ready = gnt0 && can_accept && reset;
        req1_ready = gnt1 && can_accept && reset;
        accept     = req0_ready || req1_ready;
        sel_data   = gnt1 ? req1_data : req0_data;
        sel_amt    = gnt1 ? req1_amt  : req0_amt;
        sel_op     = gnt1 ? req1_op   : req0_op;
    end

    shift_core u_core (
        .data   (sel_data),
        .amt    (sel_amt),
        .op     (sel_op),
        .result (shifted)
    );

    // Output register state machine; an accept loads data, id and the round-robin pointer
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= RES_EMPTY;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_id    <= ID_ALU;
            last      <= ID_SERVO;
        end else begin
            case (state)
                RES_EMPTY: begin
                    if (accept) begin
                        state     <= RES_FULL;
                        res_valid <= 1'b1;
                        res_data  <= shifted;
                        res_id    <= gnt1;
                        last      <= gnt1;
                    end
                end
                RES_FULL: begin
                    if (accept) begin
                        res_data <= shifted;
                        res_id   <= gnt1;
                        last     <= gnt1;
                    end else if (res_ready) begin
                        state     <= RES_EMPTY;
                        res_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= RES_EMPTY;
                    res_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_arbiter.sv
// tb/tb_shift_arbiter.sv - scoreboard bench for shift_arbiter with a reference model
module tb_shift_arbiter;

    localparam int PRIO = 0;
`ifdef SHIFT_ARBITER_SRA_EN
    localparam bit SRA_EN = 1'b1;
`else
    localparam bit SRA_EN = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_data = '0, req1_data = '0;
    logic [4:0]  req0_amt = '0, req1_amt = '0;
    logic        req0_op = 1'b0, req1_op = 1'b0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [31:0] res_data;
    logic        res_id;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] data;
        logic        id;
    } exp_t;
    exp_t sb[$];

    shift_arbiter #(.PRIO_FIXED(PRIO)) dut (
        .clock      (clock),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_data  (req0_data),
        .req0_amt   (req0_amt),
        .req0_op    (req0_op),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_data  (req1_data),
        .req1_amt   (req1_amt),
        .req1_op    (req1_op),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_id     (res_id)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] ref_shift(logic [31:0] d, logic [4:0] a, logic sra);
        if (sra) return 32'($signed(d) >>> a);
        return d << a;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor / reference model
    bit          model_last = 1'b1;
    bit          m_full, m_w, m_can, m_e0, m_e1;
    bit          prev_hold = 1'b0;
    logic [31:0] prev_data;
    logic        prev_id;
    exp_t        m_e;

    always @(negedge clock) begin
        if (!reset) begin
            chk("ready0_in_reset", req0_ready, 0);
            chk("ready1_in_reset", req1_ready, 0);
            chk("res_valid_in_reset", res_valid, 0);
            sb.delete();
            model_last = 1'b1;
            prev_hold  = 1'b0;
        end else begin
            m_full = (sb.size() != 0);
            chk("res_valid_vs_model", res_valid, m_full);
            if (prev_hold && res_valid) begin
                chk("hold_data", res_data, prev_data);
                chk("hold_id", res_id, prev_id);
            end
            if (m_full && res_ready) begin
                m_e = sb.pop_front();
                chk("res_data", res_data, m_e.data);
                chk("res_id", res_id, m_e.id);
            end
            if (req0_valid && req1_valid) m_w = (PRIO != 0) ? 1'b0 : !model_last;
            else                          m_w = req1_valid;
            m_can = !m_full || res_ready;
            m_e0  = m_can && req0_valid && !m_w;
            m_e1  = m_can && req1_valid && m_w;
            chk("req0_ready", req0_ready, m_e0);
            chk("req1_ready", req1_ready, m_e1);
            if (m_e0 || m_e1) begin
                if (m_w) sb.push_back('{data: ref_shift(req1_data, req1_amt, SRA_EN && req1_op), id: 1'b1});
                else     sb.push_back('{data: ref_shift(req0_data, req0_amt, SRA_EN && req0_op), id: 1'b0});
                model_last = m_w;
            end
            prev_hold = res_valid && !res_ready;
            prev_data = res_data;
            prev_id   = res_id;
        end
    end

    // Present one operation from a requester and hold it until accepted; returns just after the accepting edge
    task automatic issue(input bit id, input logic [31:0] d, input logic [4:0] a, input logic op);
        bit acc = 1'b0;
        if (id) begin req1_valid = 1; req1_data = d; req1_amt = a; req1_op = op; end
        else    begin req0_valid = 1; req0_data = d; req0_amt = a; req0_op = op; end
        for (int i = 0; i < 64 && !acc; i++) begin
            @(negedge clock);
            acc = id ? req1_ready : req0_ready;
            @(posedge clock); #1;
        end
        if (!acc) begin
            checks++; errors++;
            $display("FAIL issue_timeout: requester %0d never accepted", id);
        end
        if (id) req1_valid = 0; else req0_valid = 0;
    endtask

    bit a0, a1, g;

    initial begin
        repeat (3) @(posedge clock);
        #1;
        req0_valid = 1;
        #1;
        chk("reset_ready0", req0_ready, 0);
        chk("reset_res_valid", res_valid, 0);
        chk("reset_res_data", res_data, 32'h0);
        chk("reset_res_id", res_id, 0);
        req0_valid = 0;
        @(posedge clock); #1;
        reset = 1;

        // single request, SRA, pass-through
        res_ready = 1;
        issue(0, 32'h0000_0001, 5'd4, 1'b0);
        chk("single_valid", res_valid, 1);
        chk("single_data", res_data, 32'h0000_0010);
        chk("single_id", res_id, 0);
        issue(1, 32'h8000_0000, 5'd31, 1'b1);
        chk("sra_data", res_data, SRA_EN ? 32'hFFFF_FFFF : 32'h0000_0000);
        chk("sra_id", res_id, 1);
        issue(0, 32'hDEAD_BEEF, 5'd0, 1'b1);
        chk("pass_data", res_data, 32'hDEAD_BEEF);

        // back-pressure for three cycles, then drain plus accept
        res_ready = 0;
        req1_valid = 1; req1_data = 32'h3; req1_amt = 5'd1; req1_op = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            chk("bp_ready0", req0_ready, 0);
            chk("bp_ready1", req1_ready, 0);
            chk("bp_data", res_data, 32'hDEAD_BEEF);
            @(posedge clock); #1;
        end
        res_ready = 1;
        @(negedge clock);
        chk("bp_release_ready1", req1_ready, 1);
        @(posedge clock); #1;
        req1_valid = 0;
        chk("bp_refill_valid", res_valid, 1);
        chk("bp_refill_data", res_data, 32'h6);

        // reset while FULL
        issue(1, 32'h5, 5'd2, 1'b0);
        res_ready = 0;
        chk("pre_reset_valid", res_valid, 1);
        reset = 0;
        #1;
        chk("reset_async_drop", res_valid, 0);
        repeat (2) @(posedge clock);
        #1;
        reset = 1;

        // contention right after reset
        res_ready = 1;
        req0_valid = 1; req0_data = $urandom; req0_amt = 5'($urandom_range(0, 31)); req0_op = 1'($urandom_range(0, 1));
        req1_valid = 1; req1_data = $urandom; req1_amt = 5'($urandom_range(0, 31)); req1_op = 1'($urandom_range(0, 1));
        for (int k = 0; k < 8; k++) begin
            @(negedge clock);
            a0 = req0_ready; a1 = req1_ready; g = a1;
            chk("contention_any", a0 | a1, 1);
            chk("contention_order", g, (PRIO != 0) ? 0 : (k % 2));
            @(posedge clock); #1;
            if (a0) begin req0_data = $urandom; req0_amt = 5'($urandom_range(0, 31)); end
            if (a1) begin req1_data = $urandom; req1_amt = 5'($urandom_range(0, 31)); end
        end
        req0_valid = 0; req1_valid = 0;

        // randomized traffic honouring the hold-until-ready obligation
        for (int c = 0; c < 3000; c++) begin
            @(negedge clock);
            a0 = req0_valid && req0_ready;
            a1 = req1_valid && req1_ready;
            @(posedge clock); #1;
            if (!req0_valid || a0) begin
                req0_valid = 1'($urandom_range(0, 1));
                req0_data  = $urandom;
                req0_amt   = 5'($urandom_range(0, 31));
                req0_op    = 1'($urandom_range(0, 1));
            end
            if (!req1_valid || a1) begin
                req1_valid = 1'($urandom_range(0, 1));
                req1_data  = $urandom;
                req1_amt   = 5'($urandom_range(0, 31));
                req1_op    = 1'($urandom_range(0, 1));
            end
            res_ready = ($urandom_range(0, 3) != 0);
        end

        // let outstanding results hold until accepted, then drain
        for (int c = 0; c < 64 && (req0_valid || req1_valid); c++) begin
            @(negedge clock);
            a0 = req0_valid && req0_ready;
            a1 = req1_valid && req1_ready;
            @(posedge clock); #1;
            if (a0) req0_valid = 0;
            if (a1) req1_valid = 0;
            res_ready = 1;
        end
        res_ready = 1;
        repeat (4) @(posedge clock);
        #1;
        chk("final_drained", sb.size(), 0);
        chk("final_idle_valid", res_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
